isq_wakeup_bcast: RTL

//  Transmit side of the issue-queue condition-update broadcast. Collects condition-update requests

---
 rtl/isq_wakeup_bcast_pkg.sv | 26 ++
 rtl/wb_update_fifo.sv | 98 +++++++++
 rtl/isq_wakeup_bcast.sv | 110 +++++++++++
 3 files changed

// File: rtl/isq_wakeup_bcast_pkg.sv
// Shared ISQ definitions: broadcast payload, ROB state encoding and the robid age compare
// used by both the wakeup broadcaster and the ISQ flush logic.
package isq_wakeup_bcast_pkg;

   localparam int ISQ_ROBID_W = 7;
   localparam int ISQ_COND_W  = 2;

   typedef enum logic [1:0] {
      ROB_STATE_IDLE     = 2'd0,
      ROB_STATE_ROLLBACK = 2'd1
   } rob_state_e;

   typedef struct packed {
      logic [ISQ_ROBID_W-1:0] robid;
      logic [ISQ_COND_W-1:0]  mask;
      logic [ISQ_COND_W-1:0]  in;
   } wb_update_t;

   // True when r is younger than flush; the MSB is the ROB wrap bit.
   function automatic logic robid_younger(input logic [ISQ_ROBID_W-1:0] flush,
                                          input logic [ISQ_ROBID_W-1:0] r);
      return flush[ISQ_ROBID_W-1] ^ r[ISQ_ROBID_W-1] ^
             (flush[ISQ_ROBID_W-2:0] < r[ISQ_ROBID_W-2:0]);
   endfunction

endpackage

// File: rtl/wb_update_fifo.sv
// Multi-write, single-read circular buffer with per-slot live bits and a kill vector.
// Slots stay occupied when killed; only their live bit drops.
module wb_update_fifo #(
   parameter int NUM_WR = 2,
   parameter int DEPTH  = 4,
   parameter int DATA_W = 11,
   parameter int KEY_W  = 7
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_WR-1:0]         wr_en,
   input  logic [NUM_WR-1:0]         wr_live,
   input  logic [NUM_WR*DATA_W-1:0]  wr_data,
   input  logic                      rd_en,
   input  logic [DEPTH-1:0]          kill,
   output logic [DEPTH*KEY_W-1:0]    slot_key,
   output logic [DATA_W-1:0]         head_data,
   output logic                      head_live,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  live_reg;
   logic [DEPTH-1:0]  live_next;
   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic [PTR_W-1:0]  wr_idx [NUM_WR];
   logic [CNT_W-1:0]  wr_num;
   logic [CNT_W:0]    fill_sum;

   // Writers are packed densely from the tail in ascending port order.
   always_comb begin
      wr_num = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         wr_idx[i] = tail_reg + wr_num[PTR_W-1:0];
         wr_num    = wr_num + CNT_W'(wr_en[i]);
      end
   end

   always_comb begin
      live_next = live_reg & ~kill;
      if (rd_en) begin
         live_next[head_reg] = 1'b0;
      end
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_en[i]) begin
            live_next[wr_idx[i]] = wr_live[i];
         end
      end
      count_next = count_reg + wr_num - CNT_W'(rd_en);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         live_reg  <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         live_reg  <= live_next;
         head_reg  <= head_reg + PTR_W'(rd_en);
         tail_reg  <= tail_reg + wr_num[PTR_W-1:0];
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_en[i]) begin
            mem[wr_idx[i]] <= wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign slot_key[gi*KEY_W +: KEY_W] = mem[gi][DATA_W-1 -: KEY_W];
      end
   endgenerate

   assign head_data = mem[head_reg];
   assign head_live = live_reg[head_reg];
   assign count     = count_reg;

   assign fill_sum = {1'b0, count_reg} + {1'b0, wr_num};

   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      fill_sum <= DEPTH_EXT);
   a_no_underflow : assert property (@(posedge clock) disable iff (reset)
      rd_en |-> (count_reg != '0));

endmodule

// File: rtl/isq_wakeup_bcast.sv
// Transmit side of the ISQ condition-update broadcast: gathers writeback requests into an
// in-order FIFO and emits one update per cycle, dropping entries younger than a rollback flush.
module isq_wakeup_bcast
   import isq_wakeup_bcast_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int ROBID_W    = ISQ_ROBID_W,
   parameter int COND_W     = ISQ_COND_W
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*ROBID_W-1:0]  src_robid,
   input  logic [NUM_SRC*COND_W-1:0]   src_mask,
   input  logic [NUM_SRC*COND_W-1:0]   src_in,
   output logic [NUM_SRC-1:0]          src_ready,
   input  logic [1:0]                  rob_state,
   input  logic                        flush_valid,
   input  logic [ROBID_W-1:0]          flush_robid,
   output logic                        update_valid,
   output logic [ROBID_W-1:0]          update_robid,
   output logic [COND_W-1:0]           update_mask,
   output logic [COND_W-1:0]           update_in,
   output logic [$clog2(FIFO_DEPTH):0] occupancy
);

   // ROBID_W/COND_W must match the package payload widths.
   localparam int DATA_W = $bits(wb_update_t);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic [CNT_W-1:0]              count;
   logic [CNT_W-1:0]              free;
   logic [NUM_SRC-1:0]            wr_en;
   logic [NUM_SRC-1:0]            wr_live;
   logic [NUM_SRC*DATA_W-1:0]     wr_data;
   logic [FIFO_DEPTH-1:0]         kill;
   logic [FIFO_DEPTH*ROBID_W-1:0] slot_key;
   logic [DATA_W-1:0]             head_data;
   logic                          head_live;
   logic                          pop;
   logic                          flush_active;
   wb_update_t                    head;
   wb_update_t                    out_reg;

   assign flush_active = flush_valid && (rob_state == ROB_STATE_ROLLBACK);
   // Same-cycle pops are not credited, so readiness depends only on registered count.
   assign free = CNT_W'(FIFO_DEPTH) - count;
   assign pop  = (count != '0);

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         wb_update_t req;
         assign req.robid = src_robid[gi*ROBID_W +: ROBID_W];
         assign req.mask  = src_mask[gi*COND_W +: COND_W];
         assign req.in    = src_in[gi*COND_W +: COND_W];

         assign src_ready[gi] = (free >= CNT_W'(gi + 1));
         assign wr_en[gi]     = src_valid[gi] & src_ready[gi];
         // Flushed requests still take their slot so ordering and readiness are unaffected.
         assign wr_live[gi]   = !(flush_active && robid_younger(flush_robid, req.robid));
         assign wr_data[gi*DATA_W +: DATA_W] = req;
      end

      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_kill
         assign kill[gi] = flush_active &&
                           robid_younger(flush_robid, slot_key[gi*ROBID_W +: ROBID_W]);
      end
   endgenerate

   wb_update_fifo #(
      .NUM_WR (NUM_SRC),
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W),
      .KEY_W  (ROBID_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_live   (wr_live),
      .wr_data   (wr_data),
      .rd_en     (pop),
      .kill      (kill),
      .slot_key  (slot_key),
      .head_data (head_data),
      .head_live (head_live),
      .count     (count)
   );

   assign head = head_data;

   // The popped slot sees this cycle's flush as well; the value already on the bus stays.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         update_valid <= 1'b0;
         out_reg      <= '0;
      end else if (pop) begin
         update_valid <= head_live && !(flush_active && robid_younger(flush_robid, head.robid));
         out_reg      <= head;
      end else begin
         update_valid <= 1'b0;
      end
   end

   assign update_robid = out_reg.robid;
   assign update_mask  = out_reg.mask;
   assign update_in    = out_reg.in;
   assign occupancy    = count;

endmodule
